// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, 2-entry skid buffer, flush and bubbles.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_stage #(
  parameter int unsigned          CTRL_W   = 24,
  parameter int unsigned          DATA_W   = 192,
  parameter logic [CTRL_W-1:0]    CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              ready_q, ready_d;
  logic              accept, emit;

  assign accept = in_valid & ready_q;
  assign emit   = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Wrong-path: drop both slots and any beat offered this cycle.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (emit) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (accept && emit) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else if (emit) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  // Bubble: never expose a dead slot's control bits to EX.
  assign out_ctrl  = main_valid_q ? main_ctrl_q : CTRL_RST;
  assign out_data  = main_data_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid_q && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (main_valid_q || skid_valid_q)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage: directed scenarios plus randomized traffic
// checked against a 2-deep FIFO reference model.
module tb_id_ex_pipe_stage;
  localparam int CW = 24;
  localparam int DW = 192;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;
  beat_t         mq[$];
  logic [DW-1:0] m_last;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(
    .CTRL_W  (CW),
    .DATA_W  (DW),
    .CTRL_RST('0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  // Drive one cycle of inputs, advance the reference FIFO, then sample 1 time unit after the edge.
  task automatic step(input bit r, input bit f, input bit iv, input bit ordy,
                      input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit em, ac;
    beat_t b;
    reset = r; flush = f; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
    if (!r) begin
      mq.delete();
      m_last = '0;
    end else if (f) begin
      mq.delete();
    end else begin
      em = (mq.size() > 0) && ordy;
      ac = iv && (mq.size() < 2);
      if (em) void'(mq.pop_front());
      if (ac) begin
        b.c = c;
        b.d = d;
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) m_last = mq[0].d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, CW'(24'hA5), DW'(64'hDEAD));
    step(1'b0, 1'b0, 1'b1, 1'b0, CW'(24'hA5), DW'(64'hDEAD));
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'hA5), DW'(64'h1234));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_beat_valid got %b want 1", out_valid); end
    checks++; if (out_ctrl !== CW'(24'hA5)) begin errors++; $display("FAIL first_beat_ctrl got %h want a5", out_ctrl); end
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_beat_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, CW'(i + 1), DW'(32'h100 + 32'(4 * i)));
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(32'h100 + 32'(4 * i)) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h r=%b want v=1 d=%h r=1", i, out_valid, out_data,
                 in_ready, 32'h100 + 32'(4 * i));
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      errors++; $display("FAIL stream_drain got v=%b c=%h want v=0 c=0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] exp_c [3] = '{CW'(24'h22), CW'(24'h33), CW'(0)};
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h11), DW'(1));
    checks++; if (out_ctrl !== CW'(24'h11) || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_hold_a got c=%h r=%b want c=11 r=1", out_ctrl, in_ready); end
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h22), DW'(2));
    checks++; if (out_ctrl !== CW'(24'h11) || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_skid_b got c=%h r=%b want c=11 r=0", out_ctrl, in_ready); end
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h33), DW'(3));
    checks++; if (out_ctrl !== CW'(24'h11) || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_block_c got c=%h r=%b want c=11 r=0", out_ctrl, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, (i < 2), 1'b1, CW'(24'h33), DW'(3));
      checks++; if (out_ctrl !== exp_c[i] || out_valid !== (i < 2)) begin
        errors++; $display("FAIL bp_drain_%0d got c=%h v=%b want c=%h", i, out_ctrl, out_valid, exp_c[i]);
      end
    end
  endtask

  task automatic test_flush_two();
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h11), DW'(1));
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h22), DW'(2));
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush2_pre_ready got %b want 0", in_ready); end
    step(1'b1, 1'b1, 1'b1, 1'b0, CW'(24'h33), DW'(3));
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush2_state got v=%b c=%h r=%b want v=0 c=0 r=1", out_valid, out_ctrl, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_no_c_%0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_flush_emit();
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h44), DW'(4));
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flushe_pre got %b want 1", out_valid); end
    step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0) begin
      errors++; $display("FAIL flushe_empty got v=%b r=%b c=%h want v=0 r=1 c=0", out_valid, in_ready, out_ctrl);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, CW'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          out_ctrl !== ((mq.size() > 0) ? mq[0].c : CW'(0)) || out_data !== m_last) begin
        errors++;
        if (bad < 10) $display("FAIL random_%0d got v=%b r=%b c=%h want v=%b r=%b depth=%0d", i, out_valid,
                               in_ready, out_ctrl, (mq.size() > 0), (mq.size() < 2), mq.size());
        bad++;
      end
    end
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, CW'(24'h55), DW'(5));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, CW'(24'h66), DW'(6));
    step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0);
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall got %0d want 5", stall_cnt); end
    checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL perf_flush got %0d want 2", flush_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    m_last = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_two();
    test_flush_emit();
    test_random();
`ifdef ID_EX_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
